// File: rtl/irq_arb_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package     : irq_arb_pkg                                                |
// | Description : Shared widths, types and state encoding for the            |
// |               pending-interrupt arbiter and its priority encoder.        |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
package irq_arb_pkg;

    localparam int IRQ_NUM   = 32;
    localparam int IRQ_IDX_W = 5;

    typedef logic [IRQ_NUM-1:0]   irq_vec_t;
    typedef logic [IRQ_IDX_W-1:0] irq_idx_t;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        OFFER = 1'b1
    } irq_arb_state_e;

endpackage : irq_arb_pkg
`default_nettype wire

// File: rtl/priority_encoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : priority_encoder                                           |
// | Description : 32-to-5 lowest-index-first priority encoder.               |
// | Ports       : data_i  [31:0] in  - request vector                        |
// |               data_o  [4:0]  out - index of lowest set bit (0 if none)   |
// |               valid_o        out - at least one bit of data_i is set     |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module priority_encoder
    import irq_arb_pkg::*;
(
    input  logic [IRQ_NUM-1:0]   data_i,
    output logic [IRQ_IDX_W-1:0] data_o,
    output logic                 valid_o
);

    // Scan from the top down so the last hit, the lowest set index, wins.
    always_comb begin
        data_o = '0;
        for (int i = IRQ_NUM - 1; i >= 0; i--) begin
            if (data_i[i]) begin
                data_o = IRQ_IDX_W'(i);
            end
        end
    end

    assign valid_o = |data_i;

endmodule : priority_encoder
`default_nettype wire

// File: rtl/irq_pending_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : irq_pending_arbiter                                        |
// | Description : Captures 32 single-cycle event pulses into sticky pending  |
// |               bits and offers them one index at a time over a           |
// |               valid/ready handshake.                                     |
// | Ports       : clk_i          in  - clock, rising edge                    |
// |               rst_ni         in  - synchronous active-low reset          |
// |               req_i   [31:0] in  - per-bit event pulse (sets pending)    |
// |               clr_i   [31:0] in  - per-bit pending clear                 |
// |               grant_valid_o  out - offered index is valid                |
// |               grant_idx_o [4:0] out - offered index                      |
// |               grant_ready_i  in  - consumer accepts the offer            |
// |               pending_o [31:0] out - pending register                    |
// |               lost_o         out - event hit an already-pending bit      |
// | Config      : IRQ_ARB_ROUND_ROBIN_EN - when defined, search starts just  |
// |               after the last granted index; otherwise lowest index wins. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module irq_pending_arbiter
    import irq_arb_pkg::*;
(
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [IRQ_NUM-1:0]   req_i,
    input  logic [IRQ_NUM-1:0]   clr_i,
    output logic                 grant_valid_o,
    output logic [IRQ_IDX_W-1:0] grant_idx_o,
    input  logic                 grant_ready_i,
    output logic [IRQ_NUM-1:0]   pending_o,
    output logic                 lost_o
);

    localparam logic [0:0] c_ST_IDLE  = IDLE;
    localparam logic [0:0] c_ST_OFFER = OFFER;

    logic [0:0]     r_state;
    irq_vec_t       r_pending;
    logic           r_grant_valid;
    irq_idx_t       r_grant_idx;
    irq_idx_t       r_last_idx;
    logic           r_lost;

    logic           w_hs;
    irq_vec_t       w_hs_mask;
    irq_vec_t       w_pending_next;
    logic           w_lost_next;
    irq_vec_t       w_enc_data;
    irq_idx_t       w_enc_idx;
    logic           w_enc_valid;
    irq_idx_t       w_sel_idx;

    assign w_hs      = r_grant_valid & grant_ready_i;
    assign w_hs_mask = w_hs ? (irq_vec_t'(1) << r_grant_idx) : '0;

    // A new event on a bit wins over a clear or a handshake of that same
    // bit, so it is never silently dropped.
    assign w_pending_next = (r_pending & ~clr_i & ~w_hs_mask) | req_i;

    // Only a pulse that lands on a bit that will still be pending is lost;
    // a bit being cleared or handed off this cycle absorbs the new event.
    assign w_lost_next = |(req_i & r_pending & ~clr_i & ~w_hs_mask);

`ifdef IRQ_ARB_ROUND_ROBIN_EN
    irq_idx_t                w_rot;
    logic [2*IRQ_NUM-1:0]    w_dbl;
    logic [2*IRQ_NUM-1:0]    w_dbl_shr;

    // Rotate right via a doubled vector so a zero shift needs no special case.
    assign w_rot      = r_last_idx + irq_idx_t'(1);
    assign w_dbl      = {r_pending, r_pending};
    assign w_dbl_shr  = w_dbl >> w_rot;
    assign w_enc_data = w_dbl_shr[IRQ_NUM-1:0];
    assign w_sel_idx  = w_enc_idx + w_rot;
`else
    logic w_unused_last_idx;

    // The last granted index is still tracked but plays no part in
    // fixed-priority selection.
    assign w_unused_last_idx = ^r_last_idx;
    assign w_enc_data        = r_pending;
    assign w_sel_idx         = w_enc_idx;
`endif

    priority_encoder u_priority_encoder (
        .data_i  (w_enc_data),
        .data_o  (w_enc_idx),
        .valid_o (w_enc_valid)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_state       <= c_ST_IDLE;
            r_pending     <= '0;
            r_grant_valid <= 1'b0;
            r_grant_idx   <= '0;
            r_last_idx    <= irq_idx_t'(IRQ_NUM - 1);
            r_lost        <= 1'b0;
        end else begin
            r_pending <= w_pending_next;
            r_lost    <= w_lost_next;
            case (r_state)
                c_ST_IDLE: begin
                    if (w_enc_valid) begin
                        r_grant_idx   <= w_sel_idx;
                        r_grant_valid <= 1'b1;
                        r_state       <= c_ST_OFFER;
                    end
                end
                c_ST_OFFER: begin
                    // The offer stays up even if its bit is cleared meanwhile.
                    if (w_hs) begin
                        r_grant_valid <= 1'b0;
                        r_last_idx    <= r_grant_idx;
                        r_state       <= c_ST_IDLE;
                    end
                end
                default: begin
                    r_grant_valid <= 1'b0;
                    r_state       <= c_ST_IDLE;
                end
            endcase
        end
    end

    assign grant_valid_o = r_grant_valid;
    assign grant_idx_o   = r_grant_idx;
    assign pending_o     = r_pending;
    assign lost_o        = r_lost;

endmodule : irq_pending_arbiter
`default_nettype wire
